// File: rtl/nco_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : nco_freq_meter
//  Description : Gated rising-edge counter / first-to-last edge span meter
//                for a 1-bit NCO waveform, results over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_freq_meter #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_edges,
    output logic [GATE_W-1:0] res_span,
    output logic              res_ovf
);

    localparam logic [1:0]        c_st_idle = 2'd0;
    localparam logic [1:0]        c_st_meas = 2'd1;
    localparam logic [1:0]        c_st_done = 2'd2;
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] c_gate_one = GATE_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [1:0]        r_prime_cnt;
    logic              w_primed;
    logic              w_edge;

    logic [GATE_W-1:0] r_gate_cnt;
    logic [GATE_W-1:0] r_timer;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic [GATE_W-1:0] r_t_first;
    logic [GATE_W-1:0] r_t_last;

    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ovf_nxt;
    logic [GATE_W-1:0] w_t_first_nxt;
    logic [GATE_W-1:0] w_t_last_nxt;
    logic [GATE_W-1:0] w_span_nxt;

    logic [CNT_W-1:0]  r_res_edges;
    logic [GATE_W-1:0] r_res_span;
    logic              r_res_ovf;

    // Priming holds off edge detection until the cleared sync chain has
    // caught up with a level that may already be high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_prime_cnt <= 2'd0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_prime_cnt != 2'd3) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
        end
    end

    assign w_primed = (r_prime_cnt == 2'd3);
    assign w_edge   = r_s2 & ~r_s3 & w_primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (gate_len != '0) ? c_st_meas : c_st_done;
                end
            end
            c_st_meas: begin
                if (r_gate_cnt == c_gate_one) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (res_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_st_idle);
        res_valid = (r_state == c_st_done);
    end

    // Window-cycle update; also feeds the result registers so an edge in the
    // final window cycle lands in the result.
    always_comb begin
        w_count_nxt   = r_count;
        w_ovf_nxt     = r_ovf;
        w_t_first_nxt = r_t_first;
        w_t_last_nxt  = r_t_last;
        if (w_edge) begin
            if (r_count == c_cnt_max) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
            if (r_count == '0) begin
                w_t_first_nxt = r_timer;
            end
            w_t_last_nxt = r_timer;
        end
        w_span_nxt = (w_count_nxt > CNT_W'(1)) ? (w_t_last_nxt - w_t_first_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt  <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_t_first   <= '0;
            r_t_last    <= '0;
            r_res_edges <= '0;
            r_res_span  <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_gate_cnt <= gate_len;
                        r_timer    <= '0;
                        r_count    <= '0;
                        r_ovf      <= 1'b0;
                        r_t_first  <= '0;
                        r_t_last   <= '0;
                        if (gate_len == '0) begin
                            r_res_edges <= '0;
                            r_res_span  <= '0;
                            r_res_ovf   <= 1'b0;
                        end
                    end
                end
                c_st_meas: begin
                    r_gate_cnt <= r_gate_cnt - c_gate_one;
                    r_timer    <= r_timer + c_gate_one;
                    r_count    <= w_count_nxt;
                    r_ovf      <= w_ovf_nxt;
                    r_t_first  <= w_t_first_nxt;
                    r_t_last   <= w_t_last_nxt;
                    if (r_gate_cnt == c_gate_one) begin
                        r_res_edges <= w_count_nxt;
                        r_res_span  <= w_span_nxt;
                        r_res_ovf   <= w_ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_edges = r_res_edges;
    assign res_span  = r_res_span;
    assign res_ovf   = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nco_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_freq_meter
//  Description : Scoreboard bench for nco_freq_meter (default and CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_freq_meter;

    typedef struct packed {
        logic [15:0] edges;
        logic [15:0] span;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic        sig_in, sig4;
    logic        start, start4;
    logic [15:0] gate_len, gate_len4;
    logic        busy, busy4;
    logic        res_valid, res_valid4;
    logic        res_ready, res_ready4;
    logic [15:0] res_edges;
    logic [3:0]  res_edges4;
    logic [15:0] res_span, res_span4;
    logic        res_ovf, res_ovf4;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q_main[$];
    res_t q_c4[$];

    int   sig_mode  = 0;
    logic sig_level = 1'b1;
    int   ph        = 0;

    always #5 clk = ~clk;

    nco_freq_meter #(.CNT_W(16), .GATE_W(16)) u_dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .gate_len(gate_len),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_edges(res_edges), .res_span(res_span), .res_ovf(res_ovf)
    );

    nco_freq_meter #(.CNT_W(4), .GATE_W(16)) u_dut4 (
        .clk(clk), .rst(rst4), .sig_in(sig4), .start(start4), .gate_len(gate_len4),
        .busy(busy4), .res_valid(res_valid4), .res_ready(res_ready4),
        .res_edges(res_edges4), .res_span(res_span4), .res_ovf(res_ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit sel, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (sel ? res_valid4 : res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check(sel ? "timeout_c4" : "timeout_main", 0, 1);
    endtask

    // NCO stand-ins: main waveform period 10 (or constant), second toggles every cycle
    initial begin
        sig_in = 1'b1;
        sig4   = 1'b0;
        forever begin
            tick();
            ph     = (ph == 9) ? 0 : ph + 1;
            sig_in = (sig_mode == 1) ? (ph < 5) : sig_level;
            sig4   = ~sig4;
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_result", 0, 1);
            end else begin
                res_t e;
                e = q_main.pop_front();
                check("main_edges", res_edges, e.edges);
                check("main_span", res_span, e.span);
                check("main_ovf", res_ovf, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst4 && res_valid4 && res_ready4) begin
            if (q_c4.size() == 0) begin
                check("c4_unexpected_result", 0, 1);
            end else begin
                res_t e;
                e = q_c4.pop_front();
                check("c4_edges", {12'd0, res_edges4}, e.edges);
                check("c4_span", res_span4, e.span);
                check("c4_ovf", res_ovf4, e.ovf);
            end
        end
    end

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        start = 1'b0; start4 = 1'b0;
        gate_len = '0; gate_len4 = '0;
        res_ready = 1'b1; res_ready4 = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_edges", res_edges, 0);
        check("rst_span", res_span, 0);
        check("rst_ovf", res_ovf, 0);
        rst = 1'b0; rst4 = 1'b0;
        repeat (5) tick();

        // sig_in high since before reset: no edges
        q_main.push_back('{edges: 16'd0, span: 16'd0, ovf: 1'b0});
        start = 1'b1; gate_len = 16'd50;
        tick();
        start = 1'b0; gate_len = 16'd7;
        wait_valid(1'b0, 70);
        tick();

        // period 10, window 100; gate_len change after start must not matter
        sig_mode = 1;
        repeat (20) tick();
        q_main.push_back('{edges: 16'd10, span: 16'd90, ovf: 1'b0});
        start = 1'b1; gate_len = 16'd100;
        tick();
        start = 1'b0; gate_len = 16'd3;
        check("meas_busy", busy, 1);
        wait_valid(1'b0, 150);
        tick();

        // zero-length window
        res_ready = 1'b0;
        q_main.push_back('{edges: 16'd0, span: 16'd0, ovf: 1'b0});
        start = 1'b1; gate_len = 16'd0;
        tick();
        start = 1'b0;
        check("zero_valid", res_valid, 1);
        check("zero_busy", busy, 1);
        repeat (3) tick();
        check("zero_busy_hold", busy, 1);
        res_ready = 1'b1;
        tick();
        check("zero_busy_after", busy, 0);
        check("zero_valid_after", res_valid, 0);

        // backpressure with ignored start pulses
        res_ready = 1'b0;
        q_main.push_back('{edges: 16'd3, span: 16'd20, ovf: 1'b0});
        start = 1'b1; gate_len = 16'd30;
        tick();
        start = 1'b0;
        wait_valid(1'b0, 50);
        for (int i = 0; i < 20; i++) begin
            start = (i % 4 == 0); gate_len = 16'd5;
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_edges", res_edges, 3);
            check("hold_span", res_span, 20);
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        check("hold_busy_after", busy, 0);
        check("hold_valid_after", res_valid, 0);
        repeat (3) tick();
        check("no_restart_busy", busy, 0);

        // reset mid-measurement, then rerun
        start = 1'b1; gate_len = 16'd100;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        rst = 1'b0;
        repeat (5) tick();
        q_main.push_back('{edges: 16'd10, span: 16'd90, ovf: 1'b0});
        start = 1'b1; gate_len = 16'd100;
        tick();
        start = 1'b0;
        wait_valid(1'b0, 150);
        tick();

        // CNT_W=4 saturation: 32 edges in window, span from first to last
        q_c4.push_back('{edges: 16'd15, span: 16'd62, ovf: 1'b1});
        start4 = 1'b1; gate_len4 = 16'd64;
        tick();
        start4 = 1'b0;
        wait_valid(1'b1, 100);
        repeat (3) tick();

        check("main_queue_empty", q_main.size(), 0);
        check("c4_queue_empty", q_c4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
